// File: rtl/rom_stream_pkg.sv
// rtl/rom_stream_pkg.sv - shared widths and FSM state encoding for the ROM stream reader
package rom_stream_pkg;

    localparam int ROM_ADDR_W = 8;
    localparam int ROM_DATA_W = 8;
    // Byte count needs one extra bit so a full 2^ADDR_W sweep is expressible.
    localparam int ROM_LEN_W  = ROM_ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/rom_stream_fifo.sv
// rtl/rom_stream_fifo.sv - synchronous output FIFO with registered occupancy count
module rom_stream_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    // Head byte is forced to zero while empty so the stream data idles at 0.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;

    // Next storage, pointer and count values for this cycle's push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end

    // Pointers and count flush on reset; stale entries become unreachable.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - streams a run of ROM bytes out on valid/ready; ROM_STREAM_CHECKSUM_EN adds a run checksum output
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int ADDR_W     = ROM_ADDR_W,
    parameter int DATA_W     = ROM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready
`ifdef ROM_STREAM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              rd_valid_q, rd_valid_d;
    logic              issue;
    logic              accept;
    logic              credit_ok;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop;

    // A read may only go out if its byte is guaranteed a FIFO slot.
    assign credit_ok = (CNT_W'(rd_valid_q) + fifo_count) < CNT_W'(FIFO_DEPTH);
    assign m_valid   = ~fifo_empty;
    assign pop       = m_valid & m_ready;
    assign rom_ce    = issue;
    assign rom_oce   = issue;
    assign rom_ad    = addr_q;

    // Command FSM, read issue and address/remaining bookkeeping.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        issue       = 1'b0;
        accept      = 1'b0;
        done        = 1'b0;
        busy        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (length != '0)) begin
                    accept      = 1'b1;
                    addr_d      = start_addr;
                    remaining_d = length;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if ((remaining_q != '0) && credit_ok) begin
                    issue       = 1'b1;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W+1)'(1);
                    if (remaining_q == (ADDR_W+1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!rd_valid_q && fifo_empty) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Each issued read marks the following cycle's rom_dout as a FIFO write.
        rd_valid_d = issue;
    end

    // State, address, count and read-valid registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    rom_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rd_valid_q),
        .wr_data (rom_dout),
        .rd_en   (pop),
        .rd_data (m_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef ROM_STREAM_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    assign checksum = sum_q;

    // Running byte sum; cleared on command accept, frozen once the run drains.
    always_comb begin
        sum_d = sum_q;
        if (accept) begin
            sum_d = '0;
        end else if (pop) begin
            sum_d = sum_q + m_data;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

endmodule
